// File: rtl/register_file_pkg.sv
// register_file_pkg: shared register-file widths and write-transaction types.
package register_file_pkg;
    localparam int REG_INDEX_WIDTH = 2;
    localparam int REG_DATA_WIDTH  = 16;
    typedef logic [REG_INDEX_WIDTH-1:0] reg_index_t;
    typedef logic [REG_DATA_WIDTH-1:0]  reg_data_t;
    typedef struct packed {
        reg_index_t index;
        reg_data_t  data;
    } reg_write_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; pointer names the highest-priority requester.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_sel;
    logic [PW-1:0] w_pos;
    logic [PW:0]   w_sum;
    // Walk from the farthest offset back to the pointer so the nearest valid requester wins.
    always_comb begin
        grant = '0;
        w_sel = r_ptr;
        w_pos = r_ptr;
        w_sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            w_pos = (w_sum >= (PW+1)'(N)) ? PW'(w_sum - (PW+1)'(N)) : PW'(w_sum);
            if (req[w_pos]) begin
                grant = '0;
                grant[w_pos] = 1'b1;
                w_sel = w_pos;
            end
        end
        if (reset) grant = '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ptr <= '0;
        else if (advance) r_ptr <= (w_sel == PW'(N - 1)) ? '0 : w_sel + 1'b1;
    end
endmodule

// File: rtl/register_write_arbiter.sv
// register_write_arbiter: round-robin share of the register_file write port, one-cycle registered write.
module register_write_arbiter
    import register_file_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int INDEX_WIDTH = REG_INDEX_WIDTH,
    parameter int DATA_WIDTH  = REG_DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*INDEX_WIDTH-1:0] req_index,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           write_enable,
    output logic [INDEX_WIDTH-1:0]         write_index,
    output logic [DATA_WIDTH-1:0]          write_data,
    output logic                           conflict
);
    logic [NUM_REQ-1:0]     w_grant;
    logic                   w_xfer;
    logic                   w_conflict;
    logic [INDEX_WIDTH-1:0] w_idx;
    logic [DATA_WIDTH-1:0]  w_data;
    logic                   r_we;
    logic [INDEX_WIDTH-1:0] r_idx;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_conflict;
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (w_xfer),
        .grant   (w_grant)
    );
    assign req_ready = w_grant;
    assign w_xfer    = |(req_valid & w_grant);
    always_comb begin
        w_idx      = '0;
        w_data     = '0;
        w_conflict = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_idx  = w_idx  | req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
                w_data = w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int j = i + 1; j < NUM_REQ; j++)
                if (req_valid[i] && req_valid[j] &&
                    req_index[i*INDEX_WIDTH +: INDEX_WIDTH] == req_index[j*INDEX_WIDTH +: INDEX_WIDTH])
                    w_conflict = 1'b1;
        end
    end
    // Index/data hold on idle cycles; only write_enable drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_data     <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_we       <= w_xfer;
            r_conflict <= w_conflict;
            if (w_xfer) begin
                r_idx  <= w_idx;
                r_data <= w_data;
            end
        end
    end
    assign write_enable = r_we;
    assign write_index  = r_idx;
    assign write_data   = r_data;
    assign conflict     = r_conflict;
endmodule

// File: tb/tb_register_write_arbiter.sv
// tb_register_write_arbiter: directed vectors against a small register-file model fed by the write port.
module tb_register_write_arbiter;
    localparam int N  = 2;
    localparam int IW = 2;
    localparam int DW = 16;
    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*IW-1:0] req_index = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            write_enable;
    logic [IW-1:0]   write_index;
    logic [DW-1:0]   write_data;
    logic            conflict;
    logic [DW-1:0]   rf [4];
    logic [15:0]     d0, d1, exp_d;
    logic [1:0]      exp_i;
    int              n_chk = 0;
    int              n_fail = 0;
    always #5 clk = ~clk;
    register_write_arbiter #(.NUM_REQ(N), .INDEX_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_index    (req_index),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .write_enable (write_enable),
        .write_index  (write_index),
        .write_data   (write_data),
        .conflict     (conflict)
    );
    always @(posedge clk) if (write_enable) rf[write_index] <= write_data;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [1:0] v, input logic [1:0] i0, input logic [1:0] i1,
                         input logic [15:0] a, input logic [15:0] b);
        req_valid = v;
        req_index = {i1, i0};
        req_data  = {b, a};
    endtask
    initial begin
        drive(2'b11, 2'd1, 2'd2, 16'h11, 16'h22);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        step;
        @(negedge clk);
        chk("rst_ready2", 32'(req_ready), 0);
        chk("rst_we", 32'(write_enable), 0);
        step;
        reset = 1'b0;
        drive(2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        chk("idle_we", 32'(write_enable), 0);
        chk("idle_idx", 32'(write_index), 0);
        chk("idle_data", 32'(write_data), 0);
        chk("idle_conf", 32'(conflict), 0);
        chk("idle_ready", 32'(req_ready), 0);
        step;
        drive(2'b01, 2'd1, 2'd0, 16'h7, 16'h0);
        @(negedge clk);
        chk("t2_ready", 32'(req_ready), 1);
        step;
        drive(2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        chk("t2_we", 32'(write_enable), 1);
        chk("t2_idx", 32'(write_index), 1);
        chk("t2_data", 32'(write_data), 7);
        chk("t2_ready0", 32'(req_ready), 0);
        step;
        @(negedge clk);
        chk("t2_we_off", 32'(write_enable), 0);
        chk("t2_idx_hold", 32'(write_index), 1);
        chk("t2_data_hold", 32'(write_data), 7);
        chk("t2_rf1", 32'(rf[1]), 7);
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        d0 = 16'h0300;
        d1 = 16'h0500;
        exp_i = 2'd0;
        exp_d = 16'h0;
        for (int k = 0; k < 6; k++) begin
            step;
            drive(2'b11, 2'd0, 2'd2, d0, d1);
            @(negedge clk);
            chk("t3_ready", 32'(req_ready), (k % 2 == 0) ? 1 : 2);
            chk("t3_we", 32'(write_enable), (k > 0) ? 1 : 0);
            chk("t3_conf", 32'(conflict), 0);
            if (k > 0) begin
                chk("t3_idx", 32'(write_index), 32'(exp_i));
                chk("t3_data", 32'(write_data), 32'(exp_d));
            end
            if (k % 2 == 0) begin
                exp_i = 2'd0;
                exp_d = d0;
                d0 = d0 + 16'd1;
            end else begin
                exp_i = 2'd2;
                exp_d = d1;
                d1 = d1 + 16'd1;
            end
        end
        step;
        drive(2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        chk("t3_last_we", 32'(write_enable), 1);
        chk("t3_last_idx", 32'(write_index), 2);
        chk("t3_last_data", 32'(write_data), 'h0502);
        step;
        drive(2'b11, 2'd3, 2'd3, 16'hA, 16'hB);
        @(negedge clk);
        chk("t4_ready0", 32'(req_ready), 1);
        chk("t4_conf_pre", 32'(conflict), 0);
        step;
        drive(2'b10, 2'd3, 2'd3, 16'hA, 16'hB);
        @(negedge clk);
        chk("t4_ready1", 32'(req_ready), 2);
        chk("t4_conf", 32'(conflict), 1);
        chk("t4_we_a", 32'(write_enable), 1);
        chk("t4_idx_a", 32'(write_index), 3);
        chk("t4_data_a", 32'(write_data), 'hA);
        step;
        drive(2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        chk("t4_conf_clr", 32'(conflict), 0);
        chk("t4_data_b", 32'(write_data), 'hB);
        chk("t4_rf3_a", 32'(rf[3]), 'hA);
        step;
        @(negedge clk);
        chk("t4_rf3_b", 32'(rf[3]), 'hB);
        chk("t4_we_off", 32'(write_enable), 0);
        step;
        drive(2'b10, 2'd0, 2'd1, 16'h0, 16'h1234);
        @(negedge clk);
        chk("t5_ready", 32'(req_ready), 2);
        step;
        drive(2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
        reset = 1'b1;
        #1;
        chk("t5_we_async", 32'(write_enable), 0);
        @(negedge clk);
        chk("t5_we_rst", 32'(write_enable), 0);
        chk("t5_ready_rst", 32'(req_ready), 0);
        step;
        reset = 1'b0;
        drive(2'b11, 2'd0, 2'd2, 16'h00C0, 16'h0D01);
        @(negedge clk);
        chk("t5_ptr", 32'(req_ready), 1);
        chk("t5_rf1", 32'(rf[1]), 7);
        chk("t5_we", 32'(write_enable), 0);
        for (int c = 1; c <= 3; c++) begin
            step;
            drive(2'b10, 2'd0, 2'd2, 16'h0, 16'h0D00 + 16'(c));
            @(negedge clk);
            chk("t6_ready1", 32'(req_ready), 2);
            chk("t6_we", 32'(write_enable), 1);
            chk("t6_idx", 32'(write_index), (c == 1) ? 0 : 2);
            chk("t6_data", 32'(write_data), (c == 1) ? 'h00C0 : 'h0D00 + c - 1);
        end
        step;
        drive(2'b11, 2'd0, 2'd2, 16'h00C1, 16'h0D04);
        @(negedge clk);
        chk("t6_ready0", 32'(req_ready), 1);
        chk("t6_idx3", 32'(write_index), 2);
        chk("t6_data3", 32'(write_data), 'h0D03);
        step;
        drive(2'b00, 2'd0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        chk("t6_we_end", 32'(write_enable), 1);
        chk("t6_idx_end", 32'(write_index), 0);
        chk("t6_data_end", 32'(write_data), 'h00C1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
